// File: rtl/fft_frame_arbiter_if.sv
// Request/grant and FFT-control bundle between the channel side and fft_frame_arbiter.
interface fft_frame_arbiter_if;
  logic req0;
  logic req1;
  logic hold;
  logic gnt0;
  logic gnt1;
  logic ch_sel;
  logic out_ch;
  logic fft_start;
  logic fft_valid;
  logic busy;
  logic frame_done;

  modport master (
    output req0, req1, hold,
    input  gnt0, gnt1, ch_sel, out_ch, fft_start, fft_valid, busy, frame_done
  );

  modport slave (
    input  req0, req1, hold,
    output gnt0, gnt1, ch_sel, out_ch, fft_start, fft_valid, busy, frame_done
  );
endinterface

// File: rtl/fft_frame_arbiter.sv
// Two-channel round-robin frame scheduler for a shared FFT core (load / compute / unload).
// Define FFT_ARB_OVERLAP_EN to overlap the next frame's load with the previous frame's unload.
module fft_frame_arbiter (
  input logic                clk,
  input logic                rst,
  fft_frame_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    UNLOAD  = 3'd3
`ifdef FFT_ARB_OVERLAP_EN
    ,OVL    = 3'd4
`endif
  } state_t;

  localparam logic [8:0] XFER_LAST    = 9'd63;
  localparam logic [8:0] COMPUTE_LAST = 9'd159;

  state_t     state_reg, state_next;
  logic [8:0] pcnt_reg, pcnt_next;
  logic       load_ch_reg, load_ch_next;
  logic       unload_ch_reg, unload_ch_next;
  logic       last_ch_reg, last_ch_next;

  logic [1:0] req_vec;
  logic [1:0] gnt_vec;
  logic       any_req;
  logic       winner;
  logic       take_grant;
  logic       load_phase;
  logic       unload_phase;

  assign req_vec = {bus.req1, bus.req0};
  assign any_req = |req_vec;
  // last_ch_reg resets to 1 so that channel 0 wins the first tie
  assign winner  = (req_vec == 2'b11) ? ~last_ch_reg : req_vec[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      pcnt_reg      <= '0;
      load_ch_reg   <= 1'b0;
      unload_ch_reg <= 1'b0;
      last_ch_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      pcnt_reg      <= pcnt_next;
      load_ch_reg   <= load_ch_next;
      unload_ch_reg <= unload_ch_next;
      last_ch_reg   <= last_ch_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pcnt_next      = pcnt_reg;
    load_ch_next   = load_ch_reg;
    unload_ch_next = unload_ch_reg;
    last_ch_next   = last_ch_reg;
    take_grant     = 1'b0;
    // hold freezes everything, including the IDLE grant decision
    if (!bus.hold) begin
      pcnt_next = pcnt_reg + 9'd1;
      case (state_reg)
        IDLE: begin
          pcnt_next = '0;
          if (any_req) begin
            state_next = LOAD;
            take_grant = 1'b1;
          end
        end
        LOAD: begin
          if (pcnt_reg == XFER_LAST) begin
            state_next = COMPUTE;
            pcnt_next  = '0;
          end
        end
        COMPUTE: begin
          if (pcnt_reg == COMPUTE_LAST) begin
            pcnt_next      = '0;
            unload_ch_next = load_ch_reg;
`ifdef FFT_ARB_OVERLAP_EN
            if (any_req) begin
              state_next = OVL;
              take_grant = 1'b1;
            end else begin
              state_next = UNLOAD;
            end
`else
            state_next = UNLOAD;
`endif
          end
        end
        UNLOAD: begin
          if (pcnt_reg == XFER_LAST) begin
            pcnt_next = '0;
            if (any_req) begin
              state_next = LOAD;
              take_grant = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
`ifdef FFT_ARB_OVERLAP_EN
        OVL: begin
          if (pcnt_reg == XFER_LAST) begin
            state_next = COMPUTE;
            pcnt_next  = '0;
          end
        end
`endif
        default: begin
          state_next = IDLE;
          pcnt_next  = '0;
        end
      endcase
      if (take_grant) begin
        load_ch_next = winner;
        last_ch_next = winner;
      end
    end
  end

`ifdef FFT_ARB_OVERLAP_EN
  assign load_phase   = (state_reg == LOAD)   || (state_reg == OVL);
  assign unload_phase = (state_reg == UNLOAD) || (state_reg == OVL);
`else
  assign load_phase   = (state_reg == LOAD);
  assign unload_phase = (state_reg == UNLOAD);
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt_vec[gi] = load_phase && (load_ch_reg == 1'(gi));
    end
  endgenerate

  assign bus.gnt0       = gnt_vec[0];
  assign bus.gnt1       = gnt_vec[1];
  assign bus.ch_sel     = load_ch_reg;
  assign bus.out_ch     = unload_ch_reg;
  // pulses stay pending while pcnt is frozen by hold
  assign bus.fft_start  = load_phase && (pcnt_reg == '0) && !bus.hold;
  assign bus.frame_done = unload_phase && (pcnt_reg == XFER_LAST) && !bus.hold;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.fft_valid  = (state_reg != IDLE) && !bus.hold;

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Self-checking bench for fft_frame_arbiter: vector table, directed corner sequences,
// and randomized traffic against a frame-timeline reference model.
module tb_fft_frame_arbiter;

`ifdef FFT_ARB_OVERLAP_EN
  localparam bit OVL_EN = 1'b1;
`else
  localparam bit OVL_EN = 1'b0;
`endif
  localparam int BB_PERIOD = OVL_EN ? 224 : 288;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fft_frame_arbiter_if bus ();

  fft_frame_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = -1;
  bit rq[2];
  bit hd;

  // Reference model: a frame started at tick s loads in s..s+63, computes in
  // s+64..s+223 and unloads in s+224..s+287; ticks advance only without hold.
  int  m_t;
  bit  m_last;
  bit  fv[2];
  int  fs[2];
  bit  fc[2];
  bit  served[2];

  // output vector bits: gnt0 gnt1 ch_sel out_ch fft_start fft_valid busy frame_done
  function automatic logic [7:0] outvec();
    return {bus.gnt0, bus.gnt1, bus.ch_sel, bus.out_ch,
            bus.fft_start, bus.fft_valid, bus.busy, bus.frame_done};
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_last = 1'b1;
    for (int k = 0; k < 2; k++) begin
      fv[k] = 1'b0; fs[k] = 0; fc[k] = 1'b0; served[k] = 1'b0;
    end
  endtask

  function automatic void model_expect(input bit h, output logic [7:0] e, output logic [7:0] m);
    int d;
    e = 8'h00;
    m = 8'hCF;
    for (int k = 0; k < 2; k++) begin
      d = m_t - fs[k];
      if (fv[k] && d >= 0 && d <= 287) begin
        e[1] = 1'b1;
        if (d < 64) begin
          e[7 - int'(fc[k])] = 1'b1;
          e[5] = fc[k];
          m[5] = 1'b1;
          if (d == 0 && !h) e[3] = 1'b1;
        end
        if (d >= 224) begin
          e[4] = fc[k];
          m[4] = 1'b1;
          if (d == 287 && !h) e[0] = 1'b1;
        end
      end
    end
    e[2] = e[1] & !h;
  endfunction

  task automatic model_advance(input bit r0, input bit r1);
    int  d;
    bit  boundary;
    bit  w;
    d = m_t - fs[0];
    boundary = !fv[0] || d > 287 || d == 287 || (OVL_EN && d == 223);
    if (boundary && (r0 || r1)) begin
      w = (r0 && r1) ? !m_last : r1;
      fv[1] = fv[0]; fs[1] = fs[0]; fc[1] = fc[0];
      fv[0] = 1'b1;  fs[0] = m_t + 1; fc[0] = w;
      m_last = w;
      served[w] = 1'b1;
      $display("frame: ch%0d granted, load starts cycle %0d", w, cyc + 1);
    end
    m_t++;
  endtask

  task automatic step();
    logic [7:0] e, m, a;
    @(negedge clk);
    bus.req0 = rq[0];
    bus.req1 = rq[1];
    bus.hold = hd;
    #1;
    cyc++;
    model_expect(hd, e, m);
    a = outvec();
    n_cmp++;
    if ((a & m) !== (e & m)) begin
      n_bad++;
      $display("FAIL model cyc=%0d got=%b want=%b care=%b", cyc, a, e, m);
    end
    if (!hd) model_advance(rq[0], rq[1]);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rq[0] = 1'b0; rq[1] = 1'b0; hd = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.hold = 1'b0;
    #1;
    check("reset_outputs", int'(outvec()), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = -1;
  endtask

  typedef struct {
    int         cyc;
    bit         r0;
    bit         r1;
    logic [7:0] exp;
    logic [7:0] msk;
    string      name;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [7:0] a;
    int start_c, done_c, hold_good, ns, nd, g1;
    int st_c[3], st_ch[3], dn_ch[3];

    tbl[0] = '{0,   1'b1, 1'b0, 8'b0000_0000, 8'hFF, "idle_c0"};
    tbl[1] = '{1,   1'b0, 1'b0, 8'b1000_1110, 8'hEF, "load_entry_c1"};
    tbl[2] = '{2,   1'b0, 1'b0, 8'b1000_0110, 8'hEF, "load_c2"};
    tbl[3] = '{64,  1'b0, 1'b0, 8'b1000_0110, 8'hEF, "load_last_c64"};
    tbl[4] = '{65,  1'b0, 1'b0, 8'b0000_0110, 8'hCF, "compute_c65"};
    tbl[5] = '{224, 1'b0, 1'b0, 8'b0000_0110, 8'hCF, "compute_last_c224"};
    tbl[6] = '{225, 1'b0, 1'b0, 8'b0000_0110, 8'hDF, "unload_c225"};
    tbl[7] = '{288, 1'b0, 1'b0, 8'b0000_0111, 8'hDF, "done_c288"};
    tbl[8] = '{289, 1'b0, 1'b0, 8'b0000_0000, 8'hCF, "idle_c289"};

    // single frame from the vector table
    do_reset();
    foreach (tbl[k]) begin
      while (cyc + 1 < tbl[k].cyc) step();
      rq[0] = tbl[k].r0;
      rq[1] = tbl[k].r1;
      hd = 1'b0;
      step();
      a = outvec();
      n_cmp++;
      if ((a & tbl[k].msk) !== (tbl[k].exp & tbl[k].msk)) begin
        n_bad++;
        $display("FAIL %s: got %b want %b care %b", tbl[k].name, a, tbl[k].exp, tbl[k].msk);
      end
    end

    // hold for 10 cycles starting at LOAD pcnt=20
    do_reset();
    rq[0] = 1'b1;
    step();
    rq[0] = 1'b0;
    start_c = -1; done_c = -1; hold_good = 0;
    for (int i = 0; i < 400 && done_c < 0; i++) begin
      hd = (cyc + 1 >= 21) && (cyc + 1 <= 30);
      step();
      if (bus.fft_start && start_c < 0) start_c = cyc;
      if (hd && bus.gnt0 && !bus.fft_valid) hold_good++;
      if (bus.frame_done) done_c = cyc;
    end
    hd = 1'b0;
    check("hold_start_cycle", start_c, 1);
    check("hold_gnt_frozen", hold_good, 10);
    check("hold_done_delay", done_c - start_c, 297);

    // another ch0 frame, then reset at COMPUTE pcnt=80
    rq[0] = 1'b1;
    step();
    rq[0] = 1'b0;
    repeat (144) step();
    do_reset();

    // both requesting after reset: ch0 first, then alternating
    rq[0] = 1'b1; rq[1] = 1'b1;
    ns = 0; nd = 0;
    for (int k = 0; k < 3; k++) begin
      st_c[k] = -1; st_ch[k] = -1; dn_ch[k] = -1;
    end
    for (int i = 0; i < 1000 && nd < 3; i++) begin
      step();
      if (bus.fft_start && ns < 3) begin
        st_c[ns] = cyc; st_ch[ns] = int'(bus.gnt1); ns++;
      end
      if (bus.frame_done && nd < 3) begin
        dn_ch[nd] = int'(bus.out_ch); nd++;
      end
    end
    check("rst_resume_start", st_c[0], 1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("tie_order_%0d", k), st_ch[k], k % 2);
      check($sformatf("done_out_ch_%0d", k), dn_ch[k], k % 2);
    end
    check("b2b_period_1", st_c[1] - st_c[0], BB_PERIOD);
    check("b2b_period_2", st_c[2] - st_c[1], BB_PERIOD);

    // late request from ch1 during ch0 COMPUTE
    do_reset();
    rq[0] = 1'b1;
    step();
    rq[0] = 1'b0;
    g1 = -1;
    for (int i = 0; i < 600 && g1 < 0; i++) begin
      rq[1] = (cyc + 1 >= 100);
      step();
      if (bus.gnt1) g1 = cyc;
    end
    rq[1] = 1'b0;
    check("late_req_gnt1_cycle", g1, OVL_EN ? 225 : 289);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (served[c]) begin
          served[c] = 1'b0;
          if ($urandom_range(1, 0) == 0) rq[c] = 1'b0;
        end else if (!rq[c] && $urandom_range(15, 0) == 0) begin
          rq[c] = 1'b1;
        end
      end
      hd = ($urandom_range(9, 0) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
